// File: rtl/mod255_accumulator.sv
// Accumulates a job of 1..16 operands modulo 2^WIDTH-1 using an end-around-carry adder,
// then holds the result on a valid/ready interface until it is consumed.

module mod255_eac_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH:0] s;

  // Folding the carry back in cannot carry again: a carry leaves s[WIDTH-1:0] <= 2^WIDTH-2.
  assign s = {1'b0, a} + {1'b0, b};
  assign y = s[WIDTH-1:0] + WIDTH'(s[WIDTH]);
endmodule

module mod255_accumulator #(
  parameter int WIDTH = 8,
  parameter int NORM  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [4:0]       remaining;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] res_nx;

  mod255_eac_add #(.WIDTH(WIDTH)) u_add (
    .a (acc),
    .b (in_data),
    .y (acc_nx)
  );

  // All-ones is the second encoding of zero in one's-complement arithmetic.
  assign res_nx = ((NORM != 0) && (&acc_nx)) ? '0 : acc_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc       <= acc_nx;
            remaining <= remaining - 5'd1;
            if (remaining == 5'd1) begin
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              res_data  <= res_nx;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
